// File: rtl/dram_sdp_clr.sv
// dram_sdp_clr: simple-dual-port distributed RAM with one synchronous write
// port, an asynchronous or registered read port, and a post-reset clear
// sequencer that fills every word with CLEAR_VALUE before user writes are
// accepted. The array itself carries no reset so it maps onto LUT-RAM.
module dram_sdp_clr #(
  parameter int WIDTH    = 8,
  parameter int DEPTH    = 256,
  parameter int OUT_REG  = 0,
  parameter int CLEAR_EN = 1,
  parameter logic [WIDTH-1:0] CLEAR_VALUE = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [WIDTH-1:0]         wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [WIDTH-1:0]         rdata,
  output logic                     busy,
  output logic                     wr_drop
);

  localparam int AW = $clog2(DEPTH);

  localparam logic ST_CLEAR = 1'b0;
  localparam logic ST_IDLE  = 1'b1;

  logic [WIDTH-1:0] mem [DEPTH];

  logic [AW-1:0]    cnt;
  logic             mem_we;
  logic [AW-1:0]    mem_addr;
  logic [WIDTH-1:0] mem_din;

  generate
    if (CLEAR_EN != 0) begin : g_clr
      logic state;

      // Clear sequencer: walk cnt over every address once, then hand the
      // write port to the user; flag user writes that arrive while busy.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          state   <= ST_CLEAR;
          cnt     <= '0;
          wr_drop <= 1'b0;
        end else begin
          wr_drop <= (state == ST_CLEAR) && we;
          if (state == ST_CLEAR) begin
            cnt <= cnt + 1'b1;
            if (cnt == AW'(DEPTH - 1)) begin
              state <= ST_IDLE;
            end
          end
        end
      end

      assign busy = (state == ST_CLEAR);
    end else begin : g_noclr
      assign cnt     = '0;
      assign busy    = 1'b0;
      assign wr_drop = 1'b0;
    end
  endgenerate

  // Write-port ownership: the sequencer overrides the user while busy.
  always_comb begin
    mem_we   = we && !busy;
    mem_addr = waddr;
    mem_din  = wdata;
    if (busy) begin
      mem_we   = 1'b1;
      mem_addr = cnt;
      mem_din  = CLEAR_VALUE;
    end
  end

  // Storage write; no reset so the array stays distributed RAM.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[mem_addr] <= mem_din;
    end
  end

  generate
    if (OUT_REG != 0) begin : g_rreg
      logic [WIDTH-1:0] rdata_p1;

      // Registered read: nonblocking update gives read-first on collision.
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          rdata_p1 <= '0;
        end else begin
          rdata_p1 <= mem[raddr];
        end
      end

      assign rdata = rdata_p1;
    end else begin : g_rasync
      assign rdata = mem[raddr];
    end
  endgenerate

endmodule

// File: tb/tb_dram_sdp_clr.sv
// Directed bench for dram_sdp_clr: clear fill, dropped writes, read latency,
// read/write collision, mid-clear reset and randomised CLEAR_EN=0 configs.
module tb_dram_sdp_clr;

  logic        clk;
  logic        rst;
  logic        we;
  logic [7:0]  waddr, wdata, raddr;
  logic [7:0]  rdata_a, rdata_b;
  logic        busy_a, busy_b, drop_a, drop_b;

  logic        we_c;
  logic [4:0]  waddr_c, raddr_c;
  logic [0:0]  wdata_c, rdata_c;
  logic        busy_c, drop_c;

  logic        we_d;
  logic [9:0]  waddr_d, raddr_d;
  logic [63:0] wdata_d, rdata_d;
  logic        busy_d, drop_d;

  int nvec = 0;
  int nerr = 0;
  int cyc;

  logic [0:0]  mc [32];
  bit          cv [32];
  logic [63:0] md [1024];
  bit          vd [1024];
  logic [63:0] dexp;
  bit          dv;

  dram_sdp_clr #(.WIDTH(8), .DEPTH(256), .OUT_REG(0), .CLEAR_EN(1), .CLEAR_VALUE(8'hA5)) u_a (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_a), .busy(busy_a), .wr_drop(drop_a));

  dram_sdp_clr #(.WIDTH(8), .DEPTH(256), .OUT_REG(1), .CLEAR_EN(1), .CLEAR_VALUE(8'hA5)) u_b (
    .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .raddr(raddr),
    .rdata(rdata_b), .busy(busy_b), .wr_drop(drop_b));

  dram_sdp_clr #(.WIDTH(1), .DEPTH(32), .OUT_REG(0), .CLEAR_EN(0), .CLEAR_VALUE(1'b0)) u_c (
    .clk(clk), .rst(rst), .we(we_c), .waddr(waddr_c), .wdata(wdata_c), .raddr(raddr_c),
    .rdata(rdata_c), .busy(busy_c), .wr_drop(drop_c));

  dram_sdp_clr #(.WIDTH(64), .DEPTH(1024), .OUT_REG(1), .CLEAR_EN(0), .CLEAR_VALUE(64'h0)) u_d (
    .clk(clk), .rst(rst), .we(we_d), .waddr(waddr_d), .wdata(wdata_d), .raddr(raddr_d),
    .rdata(rdata_d), .busy(busy_d), .wr_drop(drop_d));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Sweep every address; async port checked immediately, registered port
  // checked one cycle later. All words hold A5 except sp_addr.
  task automatic sweep(input logic [7:0] sp_addr, input logic [7:0] sp_val);
    logic [7:0] e_prev;
    e_prev = 8'h00;
    for (int i = 0; i <= 256; i++) begin
      @(negedge clk);
      if (i > 0) chk("sweep_reg", 64'(rdata_b), 64'(e_prev));
      if (i < 256) begin
        raddr = 8'(i);
        #1;
        e_prev = (8'(i) == sp_addr) ? sp_val : 8'hA5;
        chk("sweep_async", 64'(rdata_a), 64'(e_prev));
      end
    end
  endtask

  initial begin
    rst = 1'b1;
    we = 1'b0; waddr = '0; wdata = '0; raddr = '0;
    we_c = 1'b0; waddr_c = '0; wdata_c = '0; raddr_c = '0;
    we_d = 1'b0; waddr_d = '0; wdata_d = '0; raddr_d = '0;

    // Reset state
    @(negedge clk);
    @(negedge clk);
    chk("rst_busy_a", 64'(busy_a), 64'(1));
    chk("rst_drop_a", 64'(drop_a), 64'(0));
    chk("rst_rdata_b", 64'(rdata_b), 64'(0));
    chk("rst_busy_c", 64'(busy_c), 64'(0));
    chk("rst_busy_d", 64'(busy_d), 64'(0));
    chk("rst_rdata_d", rdata_d, 64'(0));

    // Release and count the clear; drop writes at cycle 10 and at edge DEPTH
    rst = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 2000) begin
      cyc++;
      chk("drop_during_clear", 64'(drop_a), 64'(cyc == 11));
      we    = (cyc == 10) || (cyc == 256);
      waddr = (cyc == 10) ? 8'd5 : 8'd7;
      wdata = (cyc == 10) ? 8'hFF : 8'h77;
      @(negedge clk);
    end
    chk("clear_cycles", 64'(cyc), 64'(256));
    chk("drop_edge_depth", 64'(drop_a), 64'(1));
    chk("busy_b_done", 64'(busy_b), 64'(0));

    // First accepted write at edge DEPTH+1
    we = 1'b1; waddr = 8'd8; wdata = 8'h88;
    @(negedge clk);
    chk("drop_after_accept", 64'(drop_a), 64'(0));
    we = 1'b0;

    sweep(8'd8, 8'h88);

    // Write/read with registered latency
    @(negedge clk);
    we = 1'b1; waddr = 8'd17; wdata = 8'h3C;
    @(negedge clk);
    waddr = 8'd255; wdata = 8'hC3;
    @(negedge clk);
    we = 1'b0; raddr = 8'd18;
    @(negedge clk);
    raddr = 8'd17;
    #1;
    chk("async_17", 64'(rdata_a), 64'(8'h3C));
    chk("reg_17_not_yet", 64'(rdata_b), 64'(8'hA5));
    @(negedge clk);
    chk("reg_17", 64'(rdata_b), 64'(8'h3C));
    raddr = 8'd255;
    #1;
    chk("async_255", 64'(rdata_a), 64'(8'hC3));
    @(negedge clk);
    chk("reg_255", 64'(rdata_b), 64'(8'hC3));
    raddr = 8'd18;
    @(negedge clk);
    chk("reg_18", 64'(rdata_b), 64'(8'hA5));

    // Collision at address 40
    we = 1'b1; waddr = 8'd40; wdata = 8'h11;
    @(negedge clk);
    raddr = 8'd40; wdata = 8'h22;
    #1;
    chk("async_40_pre", 64'(rdata_a), 64'(8'h11));
    @(negedge clk);
    we = 1'b0;
    chk("coll_reg_old", 64'(rdata_b), 64'(8'h11));
    chk("coll_async_new", 64'(rdata_a), 64'(8'h22));
    @(negedge clk);
    chk("coll_reg_new", 64'(rdata_b), 64'(8'h22));

    // Mid-clear reset at cycle 100
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 100; i++) @(negedge clk);
    chk("busy_mid_clear", 64'(busy_a), 64'(1));
    rst = 1'b1;
    #1;
    chk("mid_rst_busy", 64'(busy_a), 64'(1));
    chk("mid_rst_rdata_b", 64'(rdata_b), 64'(0));
    @(negedge clk);
    rst = 1'b0;
    cyc = 0;
    while (busy_a && cyc < 2000) begin
      cyc++;
      @(negedge clk);
    end
    chk("reclear_cycles", 64'(cyc), 64'(256));
    sweep(8'd8, 8'hA5);

    // Random traffic on the CLEAR_EN=0 configurations
    dv = 1'b0;
    dexp = '0;
    for (int i = 0; i < 10000; i++) begin
      @(negedge clk);
      if (dv) chk("rand_d", rdata_d, dexp);
      chk("rand_ctrl_zero", 64'({busy_c, busy_d, drop_c, drop_d}), 64'(0));
      raddr_c = 5'($urandom_range(0, 31));
      raddr_d = 10'($urandom_range(0, 63));
      we_c    = 1'($urandom_range(0, 1));
      we_d    = 1'($urandom_range(0, 1));
      waddr_c = 5'($urandom_range(0, 31));
      waddr_d = 10'($urandom_range(0, 63));
      wdata_c = 1'($urandom_range(0, 1));
      wdata_d = {$urandom, $urandom};
      #1;
      if (cv[raddr_c]) chk("rand_c", 64'(rdata_c), 64'(mc[raddr_c]));
      dv   = vd[raddr_d];
      dexp = md[raddr_d];
      if (we_c) begin mc[waddr_c] = wdata_c; cv[waddr_c] = 1'b1; end
      if (we_d) begin md[waddr_d] = wdata_d; vd[waddr_d] = 1'b1; end
    end
    @(negedge clk);
    if (dv) chk("rand_d_last", rdata_d, dexp);
    we_c = 1'b0;
    we_d = 1'b0;

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/dram_sdp_clr.md
# dram_sdp_clr

Parametrised simple-dual-port distributed-RAM block: one synchronous write port, one read port with asynchronous or registered output, and a hardware clear sequencer that fills every word with a constant after reset. It generalises the single-port 256x1 LUT-RAM feature test to arbitrary width and depth, split read/write addressing and defined post-reset contents. It sits in the DRAM feature tests between switch/LED glue and must map onto RAM32M/RAM64M/RAM128X1D/RAM256X1S-class primitives without block RAM.

## Interface
- WIDTH, default 8: data width in bits, 1..64.
- DEPTH, default 256: number of words, power of two, 32..1024; AW = $clog2(DEPTH).
- OUT_REG, default 0: 0 = asynchronous read; 1 = read data registered on clk.
- CLEAR_EN, default 1: 1 = run the clear sequencer after every reset; 0 = no sequencer, contents undefined after configuration.
- CLEAR_VALUE, default 0: WIDTH-bit value written to every word by the sequencer.
- clk  input  1  single clock; all writes and registers on its rising edge.
- rst  input  1  asynchronous, active-high reset.
- we  input  1  write enable, sampled on clk.
- waddr  input  AW  write address.
- wdata  input  WIDTH  write data.
- raddr  input  AW  read address.
- rdata  output  WIDTH  read data.
- busy  output  1  high while the clear sequencer owns the write port.
- wr_drop  output  1  one-cycle pulse: a user write was discarded because busy was high.

## Operation
- Storage: DEPTH x WIDTH array, no reset on the array itself (distributed RAM cannot be reset).
- Write: on a rising clk edge with we=1 and busy=0, mem[waddr] <= wdata.
- Read, OUT_REG=0: rdata = mem[raddr] combinationally.
- Read, OUT_REG=1: rdata <= mem[raddr] on each edge, with the array value before that edge's write (read-first on collision).
- Clear sequencer (CLEAR_EN=1) has two states:
  - CLEAR: on each edge, mem[cnt] <= CLEAR_VALUE and cnt <= cnt+1. When cnt = DEPTH-1 is written, go to IDLE and deassert busy.
  - IDLE: user port owns writes; terminal state until the next reset.
- Counter width is AW; no wrap is ever taken because the transition occurs at DEPTH-1.
- During CLEAR, user we is ignored and wr_drop is asserted on the following edge for each edge where we=1. Reads are permitted and return whatever the array holds.
- CLEAR_EN=0: state is permanently IDLE, busy is tied 0 and wr_drop is tied 0.
- Reset while in CLEAR or IDLE forces CLEAR with cnt=0. The whole fill restarts.

## Timing
- Reset values: busy=1 if CLEAR_EN else 0; wr_drop=0; cnt=0; rdata=0 if OUT_REG=1.
- With OUT_REG=0, rdata is not defined during reset.
- Clear duration: the first rising edge after rst falls writes address 0. busy is low after edge DEPTH, i.e. exactly DEPTH cycles high after release.
- Write latency: data written at edge N is visible on async rdata after edge N, and on registered rdata after edge N+1.
- Read latency: 0 cycles for OUT_REG=0, 1 cycle for OUT_REG=1.
- Same-address read/write in one cycle:
  - OUT_REG=0: rdata changes to the new value after the edge.
  - OUT_REG=1: the registered output captures the old value; the new value appears one edge later.
- The first user write accepted is the one at edge DEPTH+1 after release. A write at edge DEPTH is discarded and wr_drop pulses.

## Test plan
- Clear fill (WIDTH=8, DEPTH=256, CLEAR_VALUE=8'hA5, OUT_REG=0): release rst, count busy-high cycles -> exactly 256; then sweep raddr 0..255 -> every rdata = 8'hA5.
- Write/read (OUT_REG=1): write 8'h3C to address 17 and 8'hC3 to address 255 after busy falls; read both -> 8'h3C and 8'hC3, each one cycle after raddr is applied; address 18 still reads 8'hA5.
- Collision (OUT_REG=1): address 40 holds 8'h11; same cycle we=1, waddr=raddr=40, wdata=8'h22 -> rdata=8'h11 after that edge, 8'h22 after the next edge.
- Dropped write: we=1, waddr=5, wdata=8'hFF at cycle 10 of the clear -> wr_drop pulses for one cycle; after the clear, address 5 reads 8'hA5.
- Mid-clear reset: assert rst at cycle 100 of the clear, release -> busy high a further 256 cycles, and all words read CLEAR_VALUE.
- Configuration sweep: WIDTH=1, DEPTH=32 and WIDTH=64, DEPTH=1024, CLEAR_EN=0 -> busy constantly 0; a write followed by a read of random data matches a reference model over 10k random cycles.
